// File: rtl/arith_pkg.sv
// Shared definitions for the serial add/subtract path: sequencer states and counter sizing.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 16;

    // Bit counter width; a 1-bit counter still spans 0..WIDTH-1 when WIDTH is 2.
    function automatic int cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

    localparam int CNT_W = cnt_w(DEFAULT_WIDTH);

endpackage

// File: rtl/HalfAdder.sv
// One-bit half adder used as the building block of the shared full adder.
module HalfAdder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/full_adder_1b.sv
// One-bit full adder made from two half adders and an OR on their carries.
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s1;
    logic c1;
    logic c2;

    HalfAdder u_ha0 (
        .a     (a),
        .b     (b),
        .sum   (s1),
        .carry (c1)
    );

    HalfAdder u_ha1 (
        .a     (s1),
        .b     (cin),
        .sum   (sum),
        .carry (c2)
    );

    assign cout = c1 | c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one shared full adder processes one operand bit
// per clock, LSB first, behind a start/done handshake.
module serial_add_ctrl
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int             CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             carry_out_q, carry_out_d;
    logic             overflow_q, overflow_d;

    logic fa_s;
    logic fa_cout;

    full_adder_1b u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (c_q),
        .sum  (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        c_d         = c_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1; the +1 rides in on the initial carry.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    c_d     = sub;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d = {fa_s, sum_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = fa_cout;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    carry_out_d = fa_cout;
                    overflow_d  = c_q ^ fa_cout;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            c_q         <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            c_q         <= c_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of the serial add/subtract sequencer with a result scoreboard.
module tb_serial_add_ctrl;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   last_done = 0;
    logic have_prev = 1'b0;
    logic period_en = 1'b0;
    exp_t sb[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms);
        exp_t         r;
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic [W-1:0] low;
        bb    = ms ? ~mb : mb;
        full  = {1'b0, ma} + {1'b0, bb} + (W+1)'(ms);
        low   = {1'b0, ma[W-2:0]} + {1'b0, bb[W-2:0]} + W'(ms);
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = low[W-1] ^ full[W];
        return r;
    endfunction

    // Result monitor: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_cnt++;
            $display("op %0d: sum=%h carry_out=%b overflow=%b", done_cnt, sum, carry_out, overflow);
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("sum", 64'(sum), 64'(e.sum));
                chk("carry_out", 64'(carry_out), 64'(e.cout));
                chk("overflow", 64'(overflow), 64'(e.ovf));
            end
            if (period_en && have_prev)
                chk("done_period", 64'(cyc - last_done), 64'(18));
            last_done = cyc;
            have_prev = 1'b1;
        end
    end

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                         input logic [W-1:0] esum, input logic ecout, input logic eovf);
        int lat;
        int bcnt;
        @(negedge clk);
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        sub   = ts;
        sb.push_back('{sum: esum, cout: ecout, ovf: eovf});
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        bcnt  = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        chk("latency_edges", 64'(lat - 1), 64'(W));
        chk("busy_cycles", 64'(bcnt), 64'(W));
        @(negedge clk);
        chk("done_width", 64'(done), 64'(0));
        chk("sum_held", 64'(sum), 64'(esum));
    endtask

    initial begin
        int   m;
        int   dc0;
        int   guard;
        exp_t e;

        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(carry_out), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'(0));

        do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Asynchronous reset partway through an operation.
        dc0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        a     = 16'hAAAA;
        b     = 16'h5555;
        sub   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_sum", 64'(sum), 64'(0));
        chk("abort_cout", 64'(carry_out), 64'(0));
        chk("abort_ovf", 64'(overflow), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - dc0), 64'(0));
        do_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

        // A start pulse during RUN must be dropped.
        dc0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        a     = 16'h1234;
        b     = 16'h1111;
        sub   = 1'b0;
        sb.push_back('{sum: 16'h2345, cout: 1'b0, ovf: 1'b0});
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        chk("ignored_start_dones", 64'(done_cnt - dc0), 64'(1));

        // start held high: acceptance every WIDTH+2 cycles, random operands.
        repeat (3) @(negedge clk);
        dc0       = done_cnt;
        period_en = 1'b1;
        have_prev = 1'b0;
        m         = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            start = 1'b1;
            a     = W'($urandom);
            b     = W'($urandom);
            sub   = 1'($urandom_range(0, 1));
            if (m == 0) begin
                e = model(a, b, sub);
                sb.push_back(e);
                m = W + 1;
            end else begin
                m--;
            end
        end
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (sb.size() != 0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("stream_drained", 64'(sb.size()), 64'(0));
        chk("stream_ops", 64'(done_cnt - dc0), 64'(4));
        period_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
